glitch_pulse_gen: RTL

Timing sequencer that produces the `en` window consumed by the glitch insertion core. The block works as follows:
- Armed by the host.
- Waits for an external target trigger.
- Counts a programmable delay in `clk` cycles.
- Asserts a glitch enable for a programmable width, repeated N times with programmable gaps.

It also presents the latched mode byte alongside the enable, so the core's gate selection is stable for the whole sequence.

---
 rtl/glitch_defs.sv | 25 ++
 rtl/glitch_trig_sync.sv | 27 ++
 rtl/glitch_pulse_gen.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/glitch_defs.sv
// Shared definitions for the glitch pulse sequencer: FSM states and mode bit positions.
package glitch_defs;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArmed = 3'd1,
    StDelay = 3'd2,
    StPulse = 3'd3,
    StGap   = 3'd4,
    StDone  = 3'd5
  } state_e;

  // Bit positions inside the mode byte handed to the glitch core.
  localparam int unsigned MODE_AND   = 0;
  localparam int unsigned MODE_OR    = 1;
  localparam int unsigned MODE_XOR   = 2;
  localparam int unsigned MODE_NAND  = 3;
  localparam int unsigned MODE_DEBUG = 7;

  // States in which a sequence is pending or running.
  function automatic logic is_busy(state_e s);
    return (s == StArmed) || (s == StDelay) || (s == StPulse) || (s == StGap);
  endfunction

endpackage

// File: rtl/glitch_trig_sync.sv
// Two-flop synchronizer for the asynchronous target trigger plus rising-edge detect.
module glitch_trig_sync (
  input  logic clk,
  input  logic rst,
  input  logic trig_in,
  output logic trig_edge
);

  logic sync1_q, sync2_q, hist_q;

  // Synchronizer chain followed by one history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= trig_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // One-cycle pulse on a synchronized low-to-high transition.
  assign trig_edge = sync2_q & ~hist_q;

endmodule

// File: rtl/glitch_pulse_gen.sv
// Glitch timing sequencer: arm, wait for trigger, delay, then a train of enable pulses.
module glitch_pulse_gen
  import glitch_defs::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig_in,
  input  logic             arm,
  input  logic             abort,
  input  logic [CNT_W-1:0] delay_cfg,
  input  logic [CNT_W-1:0] width_cfg,
  input  logic [CNT_W-1:0] gap_cfg,
  input  logic [REP_W-1:0] repeat_cfg,
  input  logic [7:0]       mode_cfg,
  output logic             glitch_en,
  output logic [7:0]       glitch_mode,
  output logic             armed,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [REP_W-1:0] RepOne = {{(REP_W-1){1'b0}}, 1'b1};

  logic trig_edge;

  glitch_trig_sync u_trig_sync (
    .clk       (clk),
    .rst       (rst),
    .trig_in   (trig_in),
    .trig_edge (trig_edge)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [REP_W-1:0] pulses_q, pulses_d;
  logic [7:0]       mode_q, mode_d;
  logic             glitch_en_q, glitch_en_d;
  logic             armed_q, armed_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_pulse;

  // pulses_q never exceeds rep_q-1, so the sum cannot wrap.
  assign last_pulse = ((pulses_q + RepOne) == rep_q);

  // Next-state, counter and config-latch logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    delay_d  = delay_q;
    width_d  = width_q;
    gap_d    = gap_q;
    rep_d    = rep_q;
    pulses_d = pulses_q;
    mode_d   = mode_q;

    if (abort) begin
      // Abort beats everything, including a simultaneous arm.
      state_d  = StIdle;
      cnt_d    = '0;
      pulses_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A trigger edge in the arm cycle is deliberately not consumed.
          if (arm) begin
            delay_d  = delay_cfg;
            width_d  = (width_cfg == '0) ? CntOne : width_cfg;
            gap_d    = (gap_cfg == '0) ? CntOne : gap_cfg;
            rep_d    = (repeat_cfg == '0) ? RepOne : repeat_cfg;
            mode_d   = mode_cfg;
            pulses_d = '0;
            state_d  = StArmed;
          end
        end
        StArmed: begin
          if (trig_edge) begin
            pulses_d = '0;
            if (delay_q == '0) begin
              cnt_d   = width_q;
              state_d = StPulse;
            end else begin
              cnt_d   = delay_q;
              state_d = StDelay;
            end
          end
        end
        StDelay: begin
          if (cnt_q == CntOne) begin
            cnt_d   = width_q;
            state_d = StPulse;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        StPulse: begin
          if (cnt_q == CntOne) begin
            pulses_d = pulses_q + RepOne;
            if (last_pulse) begin
              cnt_d   = '0;
              state_d = StDone;
            end else begin
              cnt_d   = gap_q;
              state_d = StGap;
            end
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        StGap: begin
          if (cnt_q == CntOne) begin
            cnt_d   = width_q;
            state_d = StPulse;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        StDone: begin
          pulses_d = '0;
          state_d  = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    // Outputs decode the next state so each flop mirrors the current state exactly.
    glitch_en_d = (state_d == StPulse);
    armed_d     = (state_d == StArmed);
    busy_d      = is_busy(state_d);
    done_d      = (state_d == StDone);
  end

  // All sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      delay_q     <= '0;
      width_q     <= '0;
      gap_q       <= '0;
      rep_q       <= '0;
      pulses_q    <= '0;
      mode_q      <= '0;
      glitch_en_q <= 1'b0;
      armed_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      delay_q     <= delay_d;
      width_q     <= width_d;
      gap_q       <= gap_d;
      rep_q       <= rep_d;
      pulses_q    <= pulses_d;
      mode_q      <= mode_d;
      glitch_en_q <= glitch_en_d;
      armed_q     <= armed_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign glitch_en   = glitch_en_q;
  assign glitch_mode = mode_q;
  assign armed       = armed_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
